// File: rtl/studio2_keypad_matrix.sv
// Multi-pad keypad controller for the Studio II core: PS/2 make/break tracking,
// minimum-hold stretching, key-select latch and per-pad active-low EF outputs.
module studio2_keypad_matrix #(
  parameter int NUM_PADS    = 2,
  parameter int KEYS        = 10,
  parameter int SEL_PORT    = 2,
  parameter int HOLD_CYCLES = 65535,
  parameter int HOLD_W      = 16
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic [10:0]            ps2_key,
  input  logic [NUM_PADS*16-1:0] ext_keys,
  input  logic                   io_out,
  input  logic [2:0]             io_n,
  input  logic [7:0]             io_dout,
  output logic [3:0]             key_sel,
  output logic [NUM_PADS-1:0]    ef_n,
  output logic [NUM_PADS*16-1:0] held,
  output logic                   any_key
);

  localparam int HW = NUM_PADS * 16;

  // Returns {valid, pad, key} for a PS/2 scan code.
  function automatic logic [5:0] decode(input logic [7:0] code);
    case (code)
      8'h45: decode = {1'b1, 1'b0, 4'd0};
      8'h16: decode = {1'b1, 1'b0, 4'd1};
      8'h1E: decode = {1'b1, 1'b0, 4'd2};
      8'h26: decode = {1'b1, 1'b0, 4'd3};
      8'h25: decode = {1'b1, 1'b0, 4'd4};
      8'h2E: decode = {1'b1, 1'b0, 4'd5};
      8'h36: decode = {1'b1, 1'b0, 4'd6};
      8'h3D: decode = {1'b1, 1'b0, 4'd7};
      8'h3E: decode = {1'b1, 1'b0, 4'd8};
      8'h46: decode = {1'b1, 1'b0, 4'd9};
      8'h70: decode = {1'b1, 1'b1, 4'd0};
      8'h69: decode = {1'b1, 1'b1, 4'd1};
      8'h72: decode = {1'b1, 1'b1, 4'd2};
      8'h7A: decode = {1'b1, 1'b1, 4'd3};
      8'h6B: decode = {1'b1, 1'b1, 4'd4};
      8'h73: decode = {1'b1, 1'b1, 4'd5};
      8'h74: decode = {1'b1, 1'b1, 4'd6};
      8'h6C: decode = {1'b1, 1'b1, 4'd7};
      8'h75: decode = {1'b1, 1'b1, 4'd8};
      8'h7D: decode = {1'b1, 1'b1, 4'd9};
      default: decode = 6'd0;
    endcase
  endfunction

  logic                             toggle_q, toggle_d;
  logic [HW-1:0]                    raw_q, raw_d;
  logic [HW-1:0]                    latched_q, latched_d;
  logic [NUM_PADS-1:0][HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]                       key_sel_q, key_sel_d;
  logic [HW-1:0]                    held_q, held_d;
  logic [NUM_PADS-1:0]              ef_n_q, ef_n_d;
  logic                             any_key_q, any_key_d;

  logic [5:0]    dec;
  logic          hit;
  logic [HW-1:0] key_mask;

  always_comb begin
    toggle_d   = ps2_key[10];
    dec        = decode(ps2_key[7:0]);
    hit        = (ps2_key[10] != toggle_q) && !ps2_key[8] && dec[5] &&
                 (int'(dec[4]) < NUM_PADS) && (int'(dec[3:0]) < KEYS);
    raw_d      = raw_q;
    latched_d  = latched_q;
    hold_cnt_d = hold_cnt_q;
    key_mask   = '0;

    for (int p = 0; p < NUM_PADS; p++) begin
      if (hold_cnt_q[p] != '0) begin
        hold_cnt_d[p] = hold_cnt_q[p] - 1'b1;
        if (hold_cnt_q[p] == HOLD_W'(1))
          latched_d[p*16 +: 16] = '0;
      end
      for (int k = 0; k < 16; k++)
        key_mask[p*16 + k] = (k < KEYS);
    end

    // A make applied after the expiry clear so the new key survives a same-cycle expiry.
    if (hit) begin
      if (ps2_key[9]) begin
        raw_d[int'(dec[4])*16 + int'(dec[3:0])] = 1'b1;
        if (HOLD_CYCLES != 0)
          latched_d[int'(dec[4])*16 + int'(dec[3:0])] = 1'b1;
        hold_cnt_d[int'(dec[4])] = HOLD_W'(HOLD_CYCLES);
      end else begin
        raw_d[int'(dec[4])*16 + int'(dec[3:0])] = 1'b0;
      end
    end

    held_d = (raw_q | latched_q | ext_keys) & key_mask;

    key_sel_d = key_sel_q;
    if (io_out && (io_n == 3'(SEL_PORT)))
      key_sel_d = io_dout[3:0];

    for (int p = 0; p < NUM_PADS; p++)
      ef_n_d[p] = ~held_q[p*16 + int'(key_sel_q)];
    any_key_d = |held_q;
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      toggle_q   <= ps2_key[10];
      raw_q      <= '0;
      latched_q  <= '0;
      hold_cnt_q <= '0;
      key_sel_q  <= '0;
      held_q     <= '0;
      ef_n_q     <= '1;
      any_key_q  <= 1'b0;
    end else begin
      toggle_q   <= toggle_d;
      raw_q      <= raw_d;
      latched_q  <= latched_d;
      hold_cnt_q <= hold_cnt_d;
      key_sel_q  <= key_sel_d;
      held_q     <= held_d;
      ef_n_q     <= ef_n_d;
      any_key_q  <= any_key_d;
    end
  end

  assign key_sel = key_sel_q;
  assign ef_n    = ef_n_q;
  assign held    = held_q;
  assign any_key = any_key_q;

endmodule

// File: tb/tb_studio2_keypad_matrix.sv
// Directed bench for studio2_keypad_matrix with three pads and a 100-cycle hold.
module tb_studio2_keypad_matrix;

  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          resetq;
  logic [10:0]   ps2_key;
  logic [NP*16-1:0] ext_keys;
  logic          io_out;
  logic [2:0]    io_n;
  logic [7:0]    io_dout;
  logic [3:0]    key_sel;
  logic [NP-1:0] ef_n;
  logic [NP*16-1:0] held;
  logic          any_key;

  int checks = 0;
  int failures = 0;

  studio2_keypad_matrix #(
    .NUM_PADS(NP), .KEYS(10), .SEL_PORT(2), .HOLD_CYCLES(100), .HOLD_W(16)
  ) dut (
    .clk(clk), .resetq(resetq), .ps2_key(ps2_key), .ext_keys(ext_keys),
    .io_out(io_out), .io_n(io_n), .io_dout(io_dout), .key_sel(key_sel),
    .ef_n(ef_n), .held(held), .any_key(any_key)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2(input logic [7:0] code, input logic pressed, input logic extd);
    ps2_key = {~ps2_key[10], pressed, extd, code};
    step(1);
  endtask

  task automatic sel(input logic [3:0] k);
    io_out = 1'b1; io_n = 3'd2; io_dout = {4'h0, k};
    step(1);
    io_out = 1'b0;
  endtask

  initial begin
    resetq = 1'b0; ps2_key = 11'h400; ext_keys = '0;
    io_out = 1'b0; io_n = 3'd0; io_dout = 8'h00;
    step(3);
    resetq = 1'b1;
    step(1);
    chk("rst_key_sel", key_sel, 0);
    chk("rst_ef_n", ef_n, 3'b111);
    chk("rst_held", held, 0);
    chk("rst_any", any_key, 0);
    step(2);
    chk("rst_no_event_held", held, 0);

    // Single press with short break, stretched to the hold time
    sel(4'd5);
    step(1);
    chk("sel5_idle", ef_n, 3'b111);
    ps2(8'h2E, 1'b1, 1'b0);                 // make edge M
    chk("make_held_lat0", held, 0);
    step(1);
    chk("make_held_lat1", held, 48'h20);
    chk("make_ef_lat1", ef_n, 3'b111);
    step(1);
    chk("make_ef_lat2", ef_n, 3'b110);
    chk("make_any", any_key, 1);
    step(7);
    ps2(8'h2E, 1'b0, 1'b0);                 // break at M+10
    step(90);                               // M+100
    chk("hold_last_held", held, 48'h20);
    chk("hold_last_ef", ef_n, 3'b110);
    step(1);
    chk("hold_exp_held", held, 0);
    step(1);
    chk("hold_exp_ef", ef_n, 3'b111);
    chk("hold_exp_any", any_key, 0);

    // Two keys held together
    ps2(8'h16, 1'b1, 1'b0);
    ps2(8'h1E, 1'b1, 1'b0);
    sel(4'd1);
    step(1);
    chk("multi_sel1", ef_n, 3'b110);
    sel(4'd2);
    step(1);
    chk("multi_sel2", ef_n, 3'b110);
    step(110);
    ps2(8'h16, 1'b0, 1'b0);
    sel(4'd1);
    step(1);
    chk("multi_rel_sel1", ef_n, 3'b111);
    sel(4'd2);
    step(1);
    chk("multi_rel_sel2", ef_n, 3'b110);
    ps2(8'h1E, 1'b0, 1'b0);
    step(2);
    chk("multi_all_rel_ef", ef_n, 3'b111);
    chk("multi_all_rel_any", any_key, 0);

    // Numpad, extended and unmapped codes
    sel(4'd5);
    step(1);
    ps2(8'h73, 1'b1, 1'b0);
    step(2);
    chk("numpad_ef", ef_n, 3'b101);
    chk("numpad_held", held, 48'h20_0000);
    ps2(8'h2E, 1'b1, 1'b1);
    step(2);
    chk("ext_ignored_ef", ef_n, 3'b101);
    ps2(8'h1C, 1'b1, 1'b0);
    step(2);
    chk("unmapped_ignored", held, 48'h20_0000);
    ps2(8'h73, 1'b0, 1'b0);
    step(105);
    chk("numpad_expired", held, 0);

    // Make landing exactly on the expiry cycle
    ps2(8'h16, 1'b1, 1'b0);                 // edge M
    ps2(8'h16, 1'b0, 1'b0);                 // M+1
    step(98);                               // M+99
    ps2(8'h1E, 1'b1, 1'b0);                 // M+100, counter 1->0 here
    step(1);
    chk("prec_new_only", held, 48'h4);
    ps2(8'h1E, 1'b0, 1'b0);                 // M+102
    step(98);                               // M+200
    chk("prec_restart_held", held, 48'h4);
    step(1);
    chk("prec_restart_exp", held, 0);

    // Select latch ignores other ports and idle strobes
    io_out = 1'b1; io_n = 3'd3; io_dout = 8'h07;
    step(1);
    io_out = 1'b0; io_n = 3'd2; io_dout = 8'h09;
    step(1);
    chk("sel_other_port", key_sel, 5);

    // Out-of-range key and third pad via ext_keys
    sel(4'd12);
    ext_keys = 48'h1000;
    step(2);
    chk("key12_held", held, 0);
    chk("key12_ef", ef_n, 3'b111);
    chk("key12_sel", key_sel, 12);
    ext_keys = 48'h8_0000_0000;
    step(1);
    sel(4'd3);
    step(1);
    chk("pad2_ef", ef_n, 3'b011);
    chk("pad2_held", held, 48'h8_0000_0000);
    chk("pad2_any", any_key, 1);

    // Reset in the middle of a hold
    ps2(8'h2E, 1'b1, 1'b0);
    step(1);
    resetq = 1'b0;
    step(1);
    chk("midrst_held", held, 0);
    chk("midrst_sel", key_sel, 0);
    chk("midrst_ef", ef_n, 3'b111);
    resetq = 1'b1;
    step(1);
    chk("postrst_held", held, 48'h8_0000_0000);
    step(2);
    chk("postrst_ef", ef_n, 3'b111);
    chk("postrst_any", any_key, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
